// File: rtl/burst_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : burst_sched_pkg
//  Description : Shared types and helpers for the burst round-robin scheduler
//  Revision    : 1.0
// ============================================================================
package burst_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HOLD  = 2'd1,
        BURST = 2'd2
    } sched_state_e;

    localparam int StatsWidth = 16;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/burst_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : burst_sched_rr_pick
//  Description : Combinational rotate-priority picker (masked upper/lower scan)
//  Revision    : 1.0
// ============================================================================
module burst_sched_rr_pick
    import burst_sched_pkg::*;
#(
    parameter int unsigned NumIn    = 4,
    parameter int unsigned IdxWidth = 2
) (
    input  logic [NumIn-1:0]    valid_i,
    input  logic [IdxWidth-1:0] prio_i,
    output logic [NumIn-1:0]    gnt_o,
    output logic [IdxWidth-1:0] idx_o,
    output logic                empty_o
);

    logic [NumIn-1:0]    mask;
    logic [NumIn-1:0]    upper;
    logic [IdxWidth-1:0] upper_idx;
    logic [IdxWidth-1:0] lower_idx;
    logic                upper_empty;

    // Index of the lowest set bit (trailing-zero count); 0 for an empty vector.
    function automatic logic [IdxWidth-1:0] first_set(input logic [NumIn-1:0] v);
        logic [IdxWidth-1:0] r;
        r = '0;
        for (int i = int'(NumIn) - 1; i >= 0; i--) begin
            if (v[i]) r = IdxWidth'(i);
        end
        return r;
    endfunction

    for (genvar i = 0; i < int'(NumIn); i++) begin : g_mask
        assign mask[i] = (IdxWidth'(i) >= prio_i);
    end

    assign upper       = valid_i & mask;
    assign upper_empty = (upper == '0);
    assign upper_idx   = first_set(upper);
    assign lower_idx   = first_set(valid_i);

    // Inputs at or above prio win first; otherwise wrap to the lowest valid.
    assign empty_o = (valid_i == '0);
    assign idx_o   = upper_empty ? lower_idx : upper_idx;
    assign gnt_o   = empty_o ? '0 : (NumIn'(1) << idx_o);

endmodule
`default_nettype wire

// File: rtl/burst_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : burst_rr_sched
//  Description : Weighted round-robin scheduler keeping multi-beat bursts whole.
//                Optional per-input completion counters: BURST_SCHED_STATS_EN
//  Revision    : 1.0
// ============================================================================
module burst_rr_sched
    import burst_sched_pkg::*;
#(
    parameter int unsigned NumIn       = 4,
    parameter int unsigned DataWidth   = 32,
    parameter int unsigned WeightWidth = 4,
    parameter int unsigned IdxWidth    = idx_width(NumIn)
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         flush_i,
    input  logic [NumIn*WeightWidth-1:0] weight_i,
    input  logic [NumIn-1:0]             inp_valid_i,
    output logic [NumIn-1:0]             inp_ready_o,
    input  logic [NumIn*DataWidth-1:0]   inp_data_i,
    input  logic [NumIn-1:0]             inp_last_i,
    output logic                         oup_valid_o,
    input  logic                         oup_ready_i,
    output logic [DataWidth-1:0]         oup_data_o,
    output logic                         oup_last_o,
    output logic [IdxWidth-1:0]          oup_idx_o,
    output logic                         busy_o
`ifdef BURST_SCHED_STATS_EN
    ,
    output logic [NumIn*StatsWidth-1:0]  txn_cnt_o
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'(IDLE);
    localparam logic [1:0] ST_HOLD  = 2'(HOLD);
    localparam logic [1:0] ST_BURST = 2'(BURST);

    logic [1:0]             state_q, state_d;
    logic [IdxWidth-1:0]    owner_q, owner_d;
    logic [IdxWidth-1:0]    prio_q,  prio_d;
    logic [WeightWidth-1:0] qcnt_q,  qcnt_d;

    logic [DataWidth-1:0]   data_arr   [NumIn];
    logic [WeightWidth-1:0] weight_arr [NumIn];

    logic [NumIn-1:0]       pick_gnt;
    logic [IdxWidth-1:0]    pick_idx;
    logic                   pick_empty;

    logic                   in_idle;
    logic [IdxWidth-1:0]    sel;
    logic [NumIn-1:0]       sel_onehot;
    logic                   hs;
    logic                   complete;
    logic [WeightWidth-1:0] qbase;
    logic [WeightWidth:0]   qnext;
    logic [WeightWidth-1:0] weight_sel;
    logic [WeightWidth-1:0] quantum;

    for (genvar i = 0; i < int'(NumIn); i++) begin : g_unpack
        assign data_arr[i]   = inp_data_i[i*DataWidth +: DataWidth];
        assign weight_arr[i] = weight_i[i*WeightWidth +: WeightWidth];
    end

    burst_sched_rr_pick #(
        .NumIn    (NumIn),
        .IdxWidth (IdxWidth)
    ) u_pick (
        .valid_i (inp_valid_i),
        .prio_i  (prio_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .empty_o (pick_empty)
    );

    // With nothing pending in IDLE the mux parks on the highest-priority input.
    assign in_idle    = (state_q == ST_IDLE);
    assign sel        = in_idle ? (pick_empty ? prio_q : pick_idx) : owner_q;
    assign sel_onehot = in_idle ? pick_gnt : (NumIn'(1) << owner_q);

    assign oup_valid_o = ~flush_i & inp_valid_i[sel];
    assign oup_data_o  = data_arr[sel];
    assign oup_last_o  = inp_last_i[sel];
    assign oup_idx_o   = sel;
    assign busy_o      = ~in_idle;

    assign hs          = oup_valid_o & oup_ready_i;
    assign inp_ready_o = {NumIn{hs}} & sel_onehot;
    assign complete    = hs & oup_last_o;

    // A new winner other than the priority holder starts a fresh quantum.
    assign qbase      = (in_idle && (sel != prio_q)) ? '0 : qcnt_q;
    assign qnext      = {1'b0, qbase} + 1'b1;
    assign weight_sel = weight_arr[sel];
    assign quantum    = (weight_sel == '0) ? WeightWidth'(1) : weight_sel;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        qcnt_d  = qcnt_q;
        if (flush_i) begin
            state_d = ST_IDLE;
            owner_d = '0;
            prio_d  = '0;
            qcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!pick_empty) begin
                        owner_d = sel;
                        qcnt_d  = qbase;
                        state_d = hs ? ST_BURST : ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (hs) state_d = ST_BURST;
                end
                ST_BURST: begin
                    state_d = ST_BURST;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            if (complete) begin
                state_d = ST_IDLE;
                if (qnext < {1'b0, quantum}) begin
                    qcnt_d = qnext[WeightWidth-1:0];
                    prio_d = sel;
                end else begin
                    qcnt_d = '0;
                    prio_d = (sel == IdxWidth'(NumIn - 1)) ? '0 : sel + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            prio_q  <= '0;
            qcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            qcnt_q  <= qcnt_d;
        end
    end

`ifdef BURST_SCHED_STATS_EN
    for (genvar i = 0; i < int'(NumIn); i++) begin : g_stats
        logic [StatsWidth-1:0] cnt_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                cnt_q <= '0;
            end else if (flush_i) begin
                cnt_q <= '0;
            end else if (complete && (sel == IdxWidth'(i)) && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign txn_cnt_o[i*StatsWidth +: StatsWidth] = cnt_q;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_burst_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_burst_rr_sched
//  Description : Directed table-driven bench for burst_rr_sched
//  Revision    : 1.0
// ============================================================================
module tb_burst_rr_sched;

    localparam int NumIn       = 4;
    localparam int DataWidth   = 32;
    localparam int WeightWidth = 4;
    localparam int IdxWidth    = 2;

    logic                         clk_i = 1'b0;
    logic                         rst_ni;
    logic                         flush_i;
    logic [NumIn*WeightWidth-1:0] weight_i;
    logic [NumIn-1:0]             inp_valid_i;
    logic [NumIn-1:0]             inp_ready_o;
    logic [NumIn*DataWidth-1:0]   inp_data_i;
    logic [NumIn-1:0]             inp_last_i;
    logic                         oup_valid_o;
    logic                         oup_ready_i;
    logic [DataWidth-1:0]         oup_data_o;
    logic                         oup_last_o;
    logic [IdxWidth-1:0]          oup_idx_o;
    logic                         busy_o;
`ifdef BURST_SCHED_STATS_EN
    logic [NumIn*16-1:0]          txn_cnt_o;
`endif

    always #5 clk_i = ~clk_i;

    burst_rr_sched #(
        .NumIn       (NumIn),
        .DataWidth   (DataWidth),
        .WeightWidth (WeightWidth)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .weight_i    (weight_i),
        .inp_valid_i (inp_valid_i),
        .inp_ready_o (inp_ready_o),
        .inp_data_i  (inp_data_i),
        .inp_last_i  (inp_last_i),
        .oup_valid_o (oup_valid_o),
        .oup_ready_i (oup_ready_i),
        .oup_data_o  (oup_data_o),
        .oup_last_o  (oup_last_o),
        .oup_idx_o   (oup_idx_o),
        .busy_o      (busy_o)
`ifdef BURST_SCHED_STATS_EN
        ,
        .txn_cnt_o   (txn_cnt_o)
`endif
    );

    typedef struct packed {
        logic       flush;
        logic [3:0] v;
        logic [3:0] l;
        logic       r;
        logic       ev;
        logic [1:0] eidx;
        logic [3:0] erdy;
        logic       ebusy;
    } vec_t;

    localparam int NVEC = 26;
    vec_t tbl [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic fl, input logic [3:0] v, input logic [3:0] l,
                                input logic r, input logic ev, input logic [1:0] eidx,
                                input logic [3:0] erdy, input logic ebusy);
        vec_t t;
        t.flush = fl; t.v = v; t.l = l; t.r = r;
        t.ev = ev; t.eidx = eidx; t.erdy = erdy; t.ebusy = ebusy;
        return t;
    endfunction

    task automatic apply(input vec_t t, input int k);
        logic [3:0] lt;
        @(negedge clk_i);
        flush_i     = t.flush;
        inp_valid_i = t.v;
        inp_last_i  = t.l;
        oup_ready_i = t.r;
        #1;
        lt = t.l;
        check($sformatf("v%0d valid", k), 32'(oup_valid_o), 32'(t.ev));
        check($sformatf("v%0d idx", k),   32'(oup_idx_o),   32'(t.eidx));
        check($sformatf("v%0d ready", k), 32'(inp_ready_o), 32'(t.erdy));
        check($sformatf("v%0d busy", k),  32'(busy_o),      32'(t.ebusy));
        check($sformatf("v%0d data", k),  oup_data_o,       32'hC0DE_0000 + 32'(t.eidx));
        check($sformatf("v%0d last", k),  32'(oup_last_o),  32'(lt[t.eidx]));
    endtask

    initial begin
        int exp2 [8];
        //                fl   v        l        r     ev    idx    rdy      busy
        // weights 1, all sources streaming single-beat transactions
        tbl[0]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        tbl[1]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        tbl[2]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        tbl[3]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
        tbl[4]  = mk(1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        // flush with prio at 1: selection scans to 3 but nothing is offered
        tbl[5]  = mk(1'b1, 4'b1001, 4'b0000, 1'b1, 1'b0, 2'd3, 4'b0000, 1'b0);
        // source 0 held for 5 stalled cycles while source 3 waits
        tbl[6]  = mk(1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0);
        tbl[7]  = mk(1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
        tbl[8]  = mk(1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
        tbl[9]  = mk(1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
        tbl[10] = mk(1'b0, 4'b1001, 4'b1000, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b1);
        tbl[11] = mk(1'b0, 4'b1001, 4'b1000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        tbl[12] = mk(1'b0, 4'b1001, 4'b1000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        tbl[13] = mk(1'b0, 4'b1001, 4'b1000, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        tbl[14] = mk(1'b0, 4'b1001, 4'b1001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b1);
        tbl[15] = mk(1'b0, 4'b1000, 4'b1000, 1'b1, 1'b1, 2'd3, 4'b1000, 1'b0);
        // source 2 burst with a 2-cycle bubble while source 1 waits
        tbl[16] = mk(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        tbl[17] = mk(1'b0, 4'b0110, 4'b0010, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
        tbl[18] = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1);
        tbl[19] = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1);
        tbl[20] = mk(1'b0, 4'b0110, 4'b0110, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b1);
        tbl[21] = mk(1'b0, 4'b0010, 4'b0010, 1'b1, 1'b1, 2'd1, 4'b0010, 1'b0);
        // flush on beat 2 of a burst from source 2, then source 0 wins
        tbl[22] = mk(1'b0, 4'b0100, 4'b0000, 1'b1, 1'b1, 2'd2, 4'b0100, 1'b0);
        tbl[23] = mk(1'b1, 4'b0100, 4'b0000, 1'b1, 1'b0, 2'd2, 4'b0000, 1'b1);
        tbl[24] = mk(1'b0, 4'b0101, 4'b0001, 1'b1, 1'b1, 2'd0, 4'b0001, 1'b0);
        // nothing valid: mux parks on prio (now 1)
        tbl[25] = mk(1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd1, 4'b0000, 1'b0);

        for (int i = 0; i < NumIn; i++) inp_data_i[i*DataWidth +: DataWidth] = 32'hC0DE_0000 + 32'(i);
        weight_i    = {4'd1, 4'd1, 4'd1, 4'd1};
        rst_ni      = 1'b0;
        flush_i     = 1'b0;
        inp_valid_i = '0;
        inp_last_i  = '0;
        oup_ready_i = 1'b0;

        #1;
        check("reset valid", 32'(oup_valid_o), 32'd0);
        check("reset idx",   32'(oup_idx_o),   32'd0);
        check("reset ready", 32'(inp_ready_o), 32'd0);
        check("reset busy",  32'(busy_o),      32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;

        for (int k = 0; k < NVEC; k++) apply(tbl[k], k);

        // weight 3 on source 1, weight 0 (treated as 1) on source 2
        @(negedge clk_i);
        flush_i = 1'b1; inp_valid_i = '0;
        weight_i = {4'd1, 4'd0, 4'd3, 4'd1};
        @(negedge clk_i);
        flush_i = 1'b0;
        exp2 = '{1, 1, 1, 2, 1, 1, 1, 2};
        for (int k = 0; k < 8; k++) begin
            if (k != 0) @(negedge clk_i);
            inp_valid_i = 4'b0110; inp_last_i = 4'b0110; oup_ready_i = 1'b1;
            #1;
            check($sformatf("wrr%0d idx", k),   32'(oup_idx_o),   32'(exp2[k]));
            check($sformatf("wrr%0d ready", k), 32'(inp_ready_o), 32'(4'b0001 << exp2[k]));
        end

`ifdef BURST_SCHED_STATS_EN
        @(negedge clk_i);
        flush_i = 1'b1; inp_valid_i = '0;
        weight_i = {4'd1, 4'd1, 4'd1, 4'd1};
        @(negedge clk_i);
        flush_i = 1'b0;
        inp_valid_i = 4'b0001; inp_last_i = 4'b0001; oup_ready_i = 1'b1;
        repeat (70000) @(negedge clk_i);
        inp_valid_i = '0;
        #1;
        check("stats saturate", 32'(txn_cnt_o[15:0]), 32'h0000_FFFF);
        @(negedge clk_i);
        flush_i = 1'b1;
        @(negedge clk_i);
        flush_i = 1'b0;
        #1;
        check("stats flush", 32'(txn_cnt_o[15:0]), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
